// File: rtl/ifu_fetch_buffer_if.sv
// IFU bus bundle: instruction-memory request/return plus the IDU read port.
// Latency: none (wires only).
// Backpressure: none here; the IFU applies credit to imem requests, the IDU pops on demand.
interface ifu_fetch_buffer_if #(
  parameter int FIFO_IFU_WIDTH = 64,
  parameter int ADDR_WIDTH     = 16
);
  logic                      imem_rd_en;
  logic [ADDR_WIDTH-1:0]     imem_addr;
  logic [FIFO_IFU_WIDTH-1:0] imem_rd_data;
  logic                      imem_rd_vld;
  logic                      idu2ifu_rd_rqst;
  logic [FIFO_IFU_WIDTH-1:0] ifu2idu_rd_data;
  logic                      ifu2idu_rd_data_vld;
  logic                      ifu2idu_fifo_empty;

  // The fetch unit side
  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rd_data, imem_rd_vld,
    input  idu2ifu_rd_rqst,
    output ifu2idu_rd_data, ifu2idu_rd_data_vld, ifu2idu_fifo_empty
  );

  // The memory / IDU side
  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rd_data, imem_rd_vld,
    output idu2ifu_rd_rqst,
    input  ifu2idu_rd_data, ifu2idu_rd_data_vld, ifu2idu_fifo_empty
  );
endinterface

// File: rtl/ifu_fetch_buffer.sv
// Instruction fetch unit: streams num_words words from imem into a FIFO popped by the IDU.
// Latency: first imem request the cycle after an accepted start; IDU data one cycle after a pop.
// Backpressure: requests issue only while FIFO occupancy plus outstanding returns is below DEPTH.
module ifu_fetch_buffer #(
  parameter int FIFO_IFU_WIDTH = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int PTR_W          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_fetch,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  ifu_fetch_buffer_if.master    bus,
  output logic [PTR_W:0]        fifo_count,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic                  fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [PTR_W:0]        CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W+1:0]      DEPTH_C  = (PTR_W+2)'(DEPTH);

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     cur_addr, num_lat, issued, received;
  logic [PTR_W:0]            outstanding;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [FIFO_IFU_WIDTH-1:0] mem [DEPTH];
  logic                      credit_ok, issue, ret_acc, pop;

  // Words in the FIFO plus words still in flight never exceed DEPTH, so a push always has room.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C;
  assign issue     = (state == FETCH) && (issued < num_lat) && credit_ok;
  assign ret_acc   = bus.imem_rd_vld && (outstanding != '0);
  assign pop       = bus.idu2ifu_rd_rqst && (fifo_count != '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: leave FETCH on the last issue so no idle cycle is spent there
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fetch) state_nxt = (num_words == '0) ? DONE : FETCH;
      FETCH:   if (issue && ((issued + ADDR_ONE) == num_lat)) state_nxt = DRAIN;
      DRAIN:   if (received == num_lat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and the current issue decision
  always_comb begin
    bus.imem_rd_en         = issue;
    bus.imem_addr          = issue ? cur_addr : '0;
    fetch_busy             = (state == FETCH) || (state == DRAIN);
    fetch_done             = (state == DONE);
    bus.ifu2idu_fifo_empty = (fifo_count == '0);
  end

  // Program registers: latch on accepted start, then advance per issue/return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr <= '0;
      num_lat  <= '0;
      issued   <= '0;
      received <= '0;
    end else if ((state == IDLE) && start_fetch) begin
      cur_addr <= base_addr;
      num_lat  <= num_words;
      issued   <= '0;
      received <= '0;
    end else begin
      if (issue) begin
        cur_addr <= cur_addr + ADDR_ONE;
        issued   <= issued + ADDR_ONE;
      end
      if (ret_acc) received <= received + ADDR_ONE;
    end
  end

  // Outstanding request count and sticky error for unsolicited returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (issue && !ret_acc)      outstanding <= outstanding + CNT_ONE;
      else if (!issue && ret_acc) outstanding <= outstanding - CNT_ONE;
      if (bus.imem_rd_vld && (outstanding == '0)) fetch_err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (ret_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (ret_acc && !pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (!ret_acc && pop) fifo_count <= fifo_count - CNT_ONE;
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (ret_acc) mem[wr_ptr] <= bus.imem_rd_data;
  end

  // Registered IDU read data; on a same-cycle push the head slot is distinct from the tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ifu2idu_rd_data     <= '0;
      bus.ifu2idu_rd_data_vld <= 1'b0;
    end else begin
      bus.ifu2idu_rd_data_vld <= pop;
      if (pop) bus.ifu2idu_rd_data <= mem[rd_ptr];
    end
  end

endmodule
